// File: rtl/dec_stage_reg.sv
// F->D pipeline register: hold, bubble flush, exception flush to handler, valid bit, exception-code merge.
// Optional saturating stall-cycle counter is built when DEC_STALL_CNT_EN is defined.
module dec_stage_reg #(
    parameter int unsigned PC_W       = 32,
    parameter int unsigned EXC_W      = 5,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter int unsigned EXC_ADEL   = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Req,
    input  logic             En,
    input  logic             Flush,
    input  logic [31:0]      instr_F,
    input  logic [PC_W-1:0]  WPC_F,
    input  logic             BD_F,
    input  logic             AdEL_sign_pc,
    input  logic [EXC_W-1:0] ExcCode_F,
    output logic [31:0]      instr_D,
    output logic [PC_W-1:0]  WPC_D,
    output logic [PC_W-1:0]  pc_8_D,
    output logic             BD_D,
    output logic [EXC_W-1:0] ExcCode_D,
    output logic             valid_D,
    output logic [4:0]       RS_D,
    output logic [4:0]       RT_D,
    output logic [4:0]       RD_D,
    output logic [4:0]       shamt_D,
    output logic [15:0]      NoneImm,
    output logic [25:0]      JPC_D,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int unsigned INSTR_W = 32;
    localparam logic [PC_W-1:0]  RST_PC_T = PC_W'(RESET_PC);
    localparam logic [PC_W-1:0]  HND_PC_T = PC_W'(HANDLER_PC);
    localparam logic [EXC_W-1:0] ADEL_T   = EXC_W'(EXC_ADEL);

    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    wpc_q,   wpc_d;
    logic               bd_q,    bd_d;
    logic [EXC_W-1:0]   exc_q,   exc_d;
    logic               valid_q, valid_d;
    logic [EXC_W-1:0]   exc_load_c;

    // Upstream code wins over a local fetch address error.
    always_comb begin
        exc_load_c = '0;
        if (ExcCode_F != '0) begin
            exc_load_c = ExcCode_F;
        end else if (AdEL_sign_pc) begin
            exc_load_c = ADEL_T;
        end
    end

    // Next state: Req > hold > bubble > load (reset handled in the register).
    always_comb begin
        instr_d = instr_q;
        wpc_d   = wpc_q;
        bd_d    = bd_q;
        exc_d   = exc_q;
        valid_d = valid_q;
        if (Req) begin
            instr_d = '0;
            wpc_d   = HND_PC_T;
            bd_d    = 1'b0;
            exc_d   = '0;
            valid_d = 1'b0;
        end else if (!En) begin
            wpc_d = WPC_F;
            bd_d  = BD_F;
            if (Flush) begin
                instr_d = '0;
                exc_d   = '0;
                valid_d = 1'b0;
            end else begin
                instr_d = AdEL_sign_pc ? '0 : instr_F;
                exc_d   = exc_load_c;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q <= '0;
            wpc_q   <= RST_PC_T;
            bd_q    <= 1'b0;
            exc_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            wpc_q   <= wpc_d;
            bd_q    <= bd_d;
            exc_q   <= exc_d;
            valid_q <= valid_d;
        end
    end

`ifdef DEC_STALL_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count held edges not overridden by Req; stick at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (!Req && En && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stall_cnt = cnt_q;
`else
    assign stall_cnt = '0;
`endif

    assign instr_D   = instr_q;
    assign WPC_D     = wpc_q;
    assign pc_8_D    = wpc_q + PC_W'(8);
    assign BD_D      = bd_q;
    assign ExcCode_D = exc_q;
    assign valid_D   = valid_q;
    assign RS_D      = instr_q[25:21];
    assign RT_D      = instr_q[20:16];
    assign RD_D      = instr_q[15:11];
    assign shamt_D   = instr_q[10:6];
    assign NoneImm   = instr_q[15:0];
    assign JPC_D     = instr_q[25:0];

endmodule

// File: doc/dec_stage_reg.md
# dec_stage_reg

Parametrised F→D pipeline register for the MIPS core, successor to the fixed 32-bit fetch/decode latch. It captures the fetched instruction, PC, delay-slot flag and exception code each cycle, and adds stall (hold), bubble-insertion flush, exception-request flush to a configurable handler PC, a valid bit, and upstream exception-code forwarding with priority. It sits between the fetch stage and decode/hazard logic. An optional saturating stall-cycle counter supports performance measurement.

## Interface
- `PC_W`, 32, PC width.
- `EXC_W`, 5, exception-code width.
- `RESET_PC`, 0, value of `WPC_D` after reset.
- `HANDLER_PC`, 32'h0000_4180, value of `WPC_D` after `Req`.
- `EXC_ADEL`, 4, code recorded for a fetch address error.
- `CNT_W`, 16, stall-counter width.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `Req` in 1: exception request; flush the stage to the handler.
- `En` in 1: stall. 1 = hold all state; 0 = advance.
- `Flush` in 1: insert a bubble in place of `instr_F`.
- `instr_F` in 32: fetched instruction.
- `WPC_F` in `PC_W`: fetch PC.
- `BD_F` in 1: instruction is in a branch delay slot.
- `AdEL_sign_pc` in 1: fetch address error.
- `ExcCode_F` in `EXC_W`: upstream exception code; 0 = none.
- `instr_D` out 32: latched instruction.
- `WPC_D` out `PC_W`: latched PC.
- `pc_8_D` out `PC_W`: `WPC_D`+8.
- `BD_D` out 1: latched delay-slot flag.
- `ExcCode_D` out `EXC_W`: latched exception code.
- `valid_D` out 1: stage holds a real instruction.
- `RS_D`/`RT_D`/`RD_D`/`shamt_D` out 5: `instr_D` bits [25:21], [20:16], [15:11] and [10:6].
- `NoneImm` out 16: `instr_D` bits [15:0].
- `JPC_D` out 26: `instr_D` bits [25:0].
- `stall_cnt` out `CNT_W`: stall-cycle counter.

## Operation
Priority per edge: `reset` > `Req` > `En` > `Flush` > normal load.

- **reset:** instr=0, WPC=`RESET_PC`, BD=0, ExcCode=0, valid=0, stall_cnt=0.
- **Req** (no reset): instr=0, WPC=`HANDLER_PC`, BD=0, ExcCode=0, valid=0. `Req` overrides `En`. stall_cnt unchanged.
- **En=1:** all state holds, including the valid bubble.
- **Flush** with `En`=0: bubble is loaded.
  - instr=0, valid=0, ExcCode=0.
  - WPC=`WPC_F`, BD=`BD_F`; keeps the EPC source correct.
  - `Flush` with `En`=1 is ignored, because the hold wins.
- **Normal load:**
  - WPC=`WPC_F`, BD=`BD_F`, valid=1.
  - ExcCode = `ExcCode_F` if nonzero; else `EXC_ADEL` if `AdEL_sign_pc`; else 0.
  - instr = 0 when `AdEL_sign_pc`=1, otherwise `instr_F`. A faulting fetch decodes as nop.
- **Arithmetic:** `pc_8_D` = (`WPC_D` + 8) mod 2^`PC_W`, combinational from the register. `PC_W` values below 32 truncate `HANDLER_PC`/`RESET_PC`.
- **Field outputs:** purely combinational slices of `instr_D`.

## Timing
- One-cycle latency from any F input to the corresponding D output.
- No combinational path from inputs to outputs.
- Reset values: instr_D=0, all fields=0, WPC_D=`RESET_PC`, pc_8_D=`RESET_PC`+8, BD_D=0, ExcCode_D=0, valid_D=0, stall_cnt=0.
- Stall of N cycles: outputs stay constant for N edges, then load on the first edge with `En`=0.
- Reset asserted mid-stall or with `Req`: reset values apply on that edge.

## Configuration
- `DEC_STALL_CNT_EN` defined:
  - `stall_cnt` increments on every edge with `En`=1, `reset`=0 and `Req`=0.
  - Saturates at all-ones.
  - Cleared only by reset.
- `DEC_STALL_CNT_EN` not defined: no counter register; `stall_cnt` is tied to 0. The port list is identical in both builds.

## Test plan
- Reset, then `instr_F`=0x8C220004, `WPC_F`=0x3000, `En`=0 → next edge: instr_D=0x8C220004, RS_D=1, RT_D=2, NoneImm=4, WPC_D=0x3000, pc_8_D=0x3008, valid_D=1.
- `En`=1 for 3 cycles while `instr_F` changes → outputs frozen. With the macro defined, stall_cnt=3.
- `Flush`=1, `En`=0, `WPC_F`=0x3010, `BD_F`=1 → instr_D=0, valid_D=0, WPC_D=0x3010, BD_D=1, ExcCode_D=0. Repeat with `En`=1 → hold.
- `AdEL_sign_pc`=1, `ExcCode_F`=0, `instr_F`=0xFFFFFFFF → instr_D=0, ExcCode_D=4. With `ExcCode_F`=10 as well → ExcCode_D=10.
- `Req`=1 together with `En`=1 → WPC_D=0x4180, pc_8_D=0x4188, instr_D=0, valid_D=0. `reset` and `Req` on the same edge → WPC_D=`RESET_PC`.
- Macro defined, `CNT_W`=2, `En`=1 for 5 cycles → stall_cnt=3, saturated.
